// File: rtl/onn_pkg.sv
// Definitions shared by the ONN pattern encoder (number_to_phase) and the phase-to-number decoder.
package onn_pkg;

    localparam int N_OSC = 60;

    // The first hex digit holds oscillators 0..3, so index 0 is the MSB of each literal.
    localparam logic [0:N_OSC-1] PAT_0 = 60'hFFFF0FF0FF0FFFF;
    localparam logic [0:N_OSC-1] PAT_1 = 60'h00F00F00F00F00F;
    localparam logic [0:N_OSC-1] PAT_2 = 60'hFFF00FFFFF00FFF;
    localparam logic [0:N_OSC-1] PAT_3 = 60'h000000000000000;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        HOLD,
        RUN,
        DONE
    } onn_state_t;

    function automatic logic [0:N_OSC-1] pattern_of(input logic [1:0] num);
        case (num)
            2'd0:    return PAT_0;
            2'd1:    return PAT_1;
            2'd2:    return PAT_2;
            default: return PAT_3;
        endcase
    endfunction

endpackage

// File: rtl/onn_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR with taps 16,14,13,11; loads seed while rst_n is low.
// Built only with NUMBER_TO_PHASE_NOISE_EN defined, because only the noisy encoder uses it.
`ifdef NUMBER_TO_PHASE_NOISE_EN
module onn_lfsr16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    output logic [15:0] lfsr
);

    logic feedback;

    assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= seed;
        end else begin
            lfsr <= {lfsr[14:0], feedback};
        end
    end

endmodule
`endif

// File: rtl/number_to_phase.sv
// Encodes a 2-bit pattern number into a serial and parallel oscillator phase load, holds it, then waits for steady.
// Define NUMBER_TO_PHASE_NOISE_EN to corrupt up to NOISE_FLIPS bits per load with an LFSR.
module number_to_phase
    import onn_pkg::*;
#(
    parameter int N_OSC       = onn_pkg::N_OSC,
    parameter int HOLD_CYCLES = 16,
    parameter int TIMEOUT     = 4096,
    parameter int NOISE_FLIPS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       num_in,
    input  logic             num_valid,
    output logic             num_ready,
    output logic             phi_ser,
    output logic             phi_ser_en,
    output logic [0:N_OSC-1] phi_init,
    output logic             init_hold,
    input  logic             steady_check,
    output logic             done,
    output logic             timeout_err,
    output logic             busy
);

    localparam int KW = $clog2(N_OSC);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam int TW = $clog2(TIMEOUT);

    onn_state_t       state;
    logic [0:N_OSC-1] new_pat;
    logic [0:N_OSC-1] pat_q;
    logic [KW-1:0]    k;
    logic [KW-1:0]    k_nxt;
    logic [HW-1:0]    hold_cnt;
    logic [TW-1:0]    run_cnt;
    logic             accept;
    logic             shift_adv;
    logic             flip_now;

    assign new_pat   = pattern_of(num_in);
    assign k_nxt     = k + 1'b1;
    assign accept    = (state == IDLE) && num_valid;
    assign shift_adv = (state == SHIFT) && (k != KW'(N_OSC - 1));

`ifdef NUMBER_TO_PHASE_NOISE_EN
    localparam int FW = $clog2(NOISE_FLIPS + 1);

    logic [15:0]   lfsr;
    logic [FW-1:0] flips;

    onn_lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (16'hACE1),
        .lfsr  (lfsr)
    );

    // The flip decision is taken on the edge that registers the bit onto phi_ser.
    assign flip_now = (lfsr[3:0] == 4'h0) && (flips < FW'(NOISE_FLIPS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flips <= '0;
        end else if (accept) begin
            flips <= FW'(flip_now);
        end else if (shift_adv) begin
            flips <= flips + FW'(flip_now);
        end
    end
`else
    assign flip_now = (NOISE_FLIPS < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            num_ready   <= 1'b1;
            phi_ser     <= 1'b0;
            phi_ser_en  <= 1'b0;
            phi_init    <= '0;
            init_hold   <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            pat_q       <= '0;
            k           <= '0;
            hold_cnt    <= '0;
            run_cnt     <= '0;
        end else begin
            done        <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (num_valid) begin
                        pat_q      <= new_pat;
                        phi_init   <= '0;
                        phi_ser    <= new_pat[0] ^ flip_now;
                        phi_ser_en <= 1'b1;
                        k          <= '0;
                        num_ready  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    // phi_ser already carries any noise, so the parallel copy mirrors the serial stream.
                    phi_init[k] <= phi_ser;
                    if (k == KW'(N_OSC - 1)) begin
                        phi_ser_en <= 1'b0;
                        phi_ser    <= 1'b0;
                        init_hold  <= 1'b1;
                        hold_cnt   <= '0;
                        state      <= HOLD;
                    end else begin
                        k       <= k_nxt;
                        phi_ser <= pat_q[k_nxt] ^ flip_now;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                        init_hold <= 1'b0;
                        run_cnt   <= '0;
                        state     <= RUN;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RUN: begin
                    // steady_check is tested first so it wins over a same-cycle timeout.
                    if (steady_check) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (run_cnt == TW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        num_ready   <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                DONE: begin
                    num_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_number_to_phase.sv
// Scoreboard bench for number_to_phase: random and directed loads checked against a cycle-level model of the protocol.
module tb_number_to_phase;

    localparam int NO   = 60;
    localparam int HOLD = 16;
    localparam int TOUT = 4096;
    localparam int NFL  = 4;
    localparam int RUN0 = 1 + NO + HOLD;  // cycles from accept to first RUN cycle

    typedef struct {
        logic [0:NO-1] pat;
        bit            to;
        int            acc;
        int            lat;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [1:0]    num_in;
    logic          num_valid;
    logic          num_ready;
    logic          phi_ser;
    logic          phi_ser_en;
    logic [0:NO-1] phi_init;
    logic          init_hold;
    logic          steady_check;
    logic          done;
    logic          timeout_err;
    logic          busy;

    logic [0:NO-1] pat_tab [4];
    logic [0:NO-1] built;
    logic [0:NO-1] last_final;
    exp_t          sb[$];
    int            cyc;
    int            steady_at;
    int            checks;
    int            fails;
    int            ser_idx;
    int            hold_seen;
    int            nflips;
    logic [15:0]   lfsr_last;

    number_to_phase dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .num_in       (num_in),
        .num_valid    (num_valid),
        .num_ready    (num_ready),
        .phi_ser      (phi_ser),
        .phi_ser_en   (phi_ser_en),
        .phi_init     (phi_init),
        .init_hold    (init_hold),
        .steady_check (steady_check),
        .done         (done),
        .timeout_err  (timeout_err),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef NUMBER_TO_PHASE_NOISE_EN
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // steady_check follows the absolute cycle chosen by the stimulus
    initial begin
        steady_check = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            steady_check = (steady_at >= 0) && (cyc >= steady_at);
        end
    end

    // Monitor: checks the serial stream every cycle and pops the scoreboard on done/timeout_err
    always @(negedge clk) begin
        logic eb;
        logic fl;
        exp_t e;
        if (!rst_n) begin
            ser_idx   = 0;
            hold_seen = 0;
            nflips    = 0;
        end else begin
            if (phi_ser_en) begin
                if (ser_idx < NO && sb.size() > 0) begin
                    fl = 1'b0;
`ifdef NUMBER_TO_PHASE_NOISE_EN
                    fl = (lfsr_last[3:0] == 4'h0) && (nflips < NFL);
`endif
                    if (fl) nflips++;
                    eb = sb[0].pat[ser_idx] ^ fl;
                    built[ser_idx] = eb;
                    chk("phi_ser", phi_ser, eb);
                    ser_idx++;
                end else begin
                    checks++;
                    fails++;
                    $display("FAIL phi_ser_en: high at serial index %0d with %0d pending loads", ser_idx, sb.size());
                end
            end
            if (init_hold) hold_seen++;
            if (done || timeout_err) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL end_pulse: done=%0b timeout_err=%0b with nothing expected", done, timeout_err);
                end else begin
                    e = sb.pop_front();
                    chk("end_kind", timeout_err, e.to);
                    chk("end_done", done, !e.to);
                    chk("latency", cyc - e.acc, e.lat);
                    chk("ser_count", ser_idx, NO);
                    chk("hold_count", hold_seen, HOLD);
`ifdef NUMBER_TO_PHASE_NOISE_EN
                    chk("phi_init", phi_init, built);
                    chk("hamming_ok", $countones(built ^ e.pat) <= NFL, 1);
`else
                    chk("phi_init", phi_init, e.pat);
`endif
                    if (timeout_err) chk("ready_after_to", num_ready, 1);
                    last_final = built;
                    ser_idx    = 0;
                    hold_seen  = 0;
                    nflips     = 0;
                end
            end
        end
`ifdef NUMBER_TO_PHASE_NOISE_EN
        lfsr_last = m_lfsr;
`endif
    end

    // Reference model: expected outcome from the protocol timing rules, pushed at accept
    task automatic load(input logic [1:0] n, input int sd);
        exp_t e;
        int   w;
        int   srel;
        w = 0;
        @(posedge clk);
        #1;
        while (!num_ready && w < 6000) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!num_ready) begin
            checks++;
            fails++;
            $display("FAIL ready_wait: num_ready still %0b after %0d cycles", num_ready, w);
            return;
        end
        num_in    = n;
        num_valid = 1'b1;
        if (sd >= 0) steady_at = cyc + sd;
        e.acc = cyc;
        e.pat = pat_tab[n];
        if (steady_at < 0) begin
            e.to  = 1'b1;
            e.lat = RUN0 + TOUT;
        end else begin
            srel = steady_at - cyc;
            if (srel < RUN0) srel = RUN0;
            if (srel <= RUN0 + TOUT - 1) begin
                e.to  = 1'b0;
                e.lat = srel + 1;
            end else begin
                e.to  = 1'b1;
                e.lat = RUN0 + TOUT;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        num_valid = 1'b0;
        chk("ready_low", num_ready, 0);
        chk("busy_high", busy, 1);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 6000) begin
            @(posedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL sb_drain: %0d loads never completed", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, num_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ser_en"}, phi_ser_en, 0);
        chk({tag, "_ser"}, phi_ser, 0);
        chk({tag, "_hold"}, init_hold, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_to"}, timeout_err, 0);
        chk({tag, "_phi_init"}, phi_init, 0);
    endtask

    initial begin
        checks     = 0;
        fails      = 0;
        rst_n      = 1'b1;
        num_valid  = 1'b0;
        num_in     = 2'd0;
        steady_at  = -1;
        lfsr_last  = 16'h0;
        built      = '0;
        last_final = '0;
        pat_tab[0] = 60'hFFFF0FF0FF0FFFF;
        pat_tab[1] = 60'h00F00F00F00F00F;
        pat_tab[2] = 60'hFFF00FFFFF00FFF;
        pat_tab[3] = 60'h000000000000000;

        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Pattern 0, steady arrives well into RUN
        load(2'd0, 100);
        wait_idle();
        chk("phi_init_kept_0", phi_init, last_final);

        // Pattern 1 with steady_check high since before the load
        steady_at = 0;
        repeat (3) @(posedge clk);
        load(2'd1, 0);
        wait_idle();
        steady_at = -1;

        // Pattern 3, steady never comes -> timeout
        load(2'd3, -1);
        wait_idle();
        chk("phi_init_kept_3", phi_init, last_final);
        chk("idle_after_to", busy, 0);

        // Pattern 2 with a stray request during HOLD
        load(2'd2, 150);
        repeat (66) @(posedge clk);
        #1;
        chk("hold_phase_busy", init_hold, 1);
        num_in    = 2'd0;
        num_valid = 1'b1;
        @(posedge clk);
        #1 num_valid = 1'b0;
        wait_idle();

        // Asynchronous reset while bit 30 is on phi_ser
        load(2'd0, 50);
        repeat (30) @(posedge clk);
        #1;
        chk("mid_shift_ser_en", phi_ser_en, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        sb.delete();
        steady_at = -1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        load(2'd0, 90);
        wait_idle();

        for (int i = 0; i < 6; i++) begin
            load(2'($urandom_range(0, 3)), int'($urandom_range(0, 200)));
            wait_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
